// File: rtl/cnn_acc_pkg.sv
// Shared constants, packed activation type and the round/shift/saturate helper
// used by the cell result drain.
package cnn_acc_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_W      = 4 * DATA_WIDTH;

  typedef logic [3:0][DATA_WIDTH-1:0] packed_act_t;

  // Round-half-up then arithmetic shift, done one bit wider so the round add cannot wrap.
  function automatic logic signed [DATA_WIDTH-1:0] sat_round_shift(
    input logic signed [ACC_W-1:0] v,
    input int unsigned             s
  );
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] one;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] qmax;
    logic signed [ACC_W:0] qmin;
    ext  = {v[ACC_W-1], v};
    one  = '0;
    one[0] = 1'b1;
    qmax = {{(ACC_W+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    qmin = {{(ACC_W+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    if (s > 0) rnd = (ext + (one << (s - 1))) >>> s;
    else       rnd = ext;
    if (rnd > qmax)      return qmax[DATA_WIDTH-1:0];
    else if (rnd < qmin) return qmin[DATA_WIDTH-1:0];
    else                 return rnd[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with async active-low reset and synchronous clear; exposes count/full/empty.
module result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cell_result_drain.sv
// Captures four accumulator results, requantizes to signed bytes, packs and buffers them.
// Optional ReLU after saturation when RESULT_DRAIN_RELU_EN is defined.
module cell_result_drain #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int ROWS_PER_TILE = 4,
  parameter int SHIFT_WIDTH   = 5
) (
  input  logic                           Clk,
  input  logic                           rst,
  input  logic                           Clear,
  input  logic                           Result_valid,
  output logic                           Result_ready,
  input  logic signed [4*DATA_WIDTH-1:0] ResultIn_0,
  input  logic signed [4*DATA_WIDTH-1:0] ResultIn_1,
  input  logic signed [4*DATA_WIDTH-1:0] ResultIn_2,
  input  logic signed [4*DATA_WIDTH-1:0] ResultIn_3,
  input  logic [SHIFT_WIDTH-1:0]         Quant_shift,
  output logic                           Out_valid,
  input  logic                           Out_ready,
  output logic [4*DATA_WIDTH-1:0]        Out_data,
  output logic                           Out_last,
  output logic                           Overflow_err
);

  import cnn_acc_pkg::*;

  localparam int AW = 4 * DATA_WIDTH;
  localparam int FW = AW + 1;
  localparam int TW = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;

  logic                   s1_valid;
  logic signed [AW-1:0]   s1_data [4];
  logic [SHIFT_WIDTH-1:0] s1_shift;
  logic                   s1_last;
  logic [TW-1:0]          tile_cnt;
  logic                   accept;
  logic                   tile_end;
  packed_act_t            q;

  logic [FW-1:0]               fifo_rd;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;

  // Counting the stage-1 word reserves its FIFO slot before it is pushed.
  assign Result_ready = rst && !fifo_full &&
                        ((int'(fifo_count) + int'(s1_valid)) < FIFO_DEPTH);
  assign accept   = Result_valid && Result_ready;
  assign tile_end = (tile_cnt == TW'(ROWS_PER_TILE - 1));

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      s1_valid     <= 1'b0;
      s1_shift     <= '0;
      s1_last      <= 1'b0;
      tile_cnt     <= '0;
      Overflow_err <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) s1_data[i] <= '0;
    end else if (Clear) begin
      s1_valid     <= 1'b0;
      tile_cnt     <= '0;
      Overflow_err <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data[0] <= ResultIn_0;
        s1_data[1] <= ResultIn_1;
        s1_data[2] <= ResultIn_2;
        s1_data[3] <= ResultIn_3;
        s1_shift   <= Quant_shift;
        s1_last    <= tile_end;
        tile_cnt   <= tile_end ? '0 : tile_cnt + 1'b1;
      end
      if (Result_valid && !Result_ready) Overflow_err <= 1'b1;
    end
  end

  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      q[i] = sat_round_shift(s1_data[i], 32'(s1_shift));
`ifdef RESULT_DRAIN_RELU_EN
      if (q[i][DATA_WIDTH-1]) q[i] = '0;
`endif
    end
  end

  result_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (rst),
    .clear   (Clear),
    .push    (s1_valid),
    .wr_data ({s1_last, q}),
    .pop     (Out_valid && Out_ready),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign Out_valid = !fifo_empty;
  assign Out_data  = fifo_rd[AW-1:0];
  assign Out_last  = fifo_rd[AW];

endmodule
